sync_fifo_ctrl: RTL and testbench
=================================

// Module: sync_fifo_ctrl
// PURPOSE
//  Parametrised single-clock FIFO: pointers, occupancy count, status flags and
//  optional first-word-fall-through (FWFT) output stage around a 2-port RAM.
//  Standard buffer between producer/consumer pipeline stages in the fifo tree.
//  Adds almost-full/almost-empty thresholds and overflow/underflow error pulses.
// PARAMETERS
//  DATA_WIDTH     8   word width in bits
//  ADDR_WIDTH     4   RAM address width; DEPTH = 2**ADDR_WIDTH
//  AFULL_THRESH  12   almost_full asserted when count >= AFULL_THRESH
//  AEMPTY_THRESH  2   almost_empty asserted when count <= AEMPTY_THRESH
//  FWFT           0   0 = standard registered read, 1 = first-word-fall-through
// PORTS
//  clk           in   1             rising-edge clock
//  rst           in   1             asynchronous reset, active-high
//  wr_en         in   1             write request
//  wr_data       in   DATA_WIDTH    write data
//  full          out  1             count == DEPTH
//  almost_full   out  1             count >= AFULL_THRESH
//  overflow      out  1             1-cycle pulse: wr_en while full (write dropped)
//  rd_en         in   1             read request (FWFT: pop/acknowledge)
//  rd_data       out  DATA_WIDTH    read data
//  rd_valid      out  1             rd_data valid (see BEHAVIOUR)
//  empty         out  1             no word available to read
//  almost_empty  out  1             count <= AEMPTY_THRESH
//  underflow     out  1             1-cycle pulse: rd_en while empty (read dropped)
//  count         out  ADDR_WIDTH+1  words held, 0..DEPTH
// BEHAVIOUR
//  - Reset (async assert, sync release): pointers=0, count=0, full=0,
//    almost_full=0, empty=1, almost_empty=1, rd_valid=0, rd_data=0,
//    overflow=0, underflow=0. RAM contents not reset. Reset mid-operation
//    discards all stored data; post-reset reads return nothing until new writes.
//  - Pointers ADDR_WIDTH+1 bits; low bits address RAM, MSB is wrap bit.
//    Pointers wrap DEPTH-1 -> 0 with MSB toggle; no special case at wrap.
//  - Write accepted iff wr_en && !full. Read accepted iff rd_en && !empty.
//    Rejected requests change no state; they only raise overflow/underflow.
//  - count: +1 on accepted write only, -1 on accepted read only, unchanged
//    when both accepted. All flags are registered, derived from next count.
//  - Full: write rejected even if an accepted read occurs same cycle
//    (no pass-through). Empty: read rejected even with same-cycle write.
//  - FWFT=0: accepted read at edge N -> rd_data = RAM[rd_ptr] and rd_valid=1
//    after edge N+1; rd_valid is a 1-cycle pulse per accepted read; rd_data
//    holds last value otherwise. empty deasserts 1 cycle after the first write.
//  - FWFT=1: output register holds head word; rd_valid = !empty = output
//    register occupied. rd_en with rd_valid pops; the next word is prefetched
//    from RAM and appears 1 cycle later (rd_valid low that cycle unless a
//    second register stage is implemented; this block uses single stage).
//    Write into empty FIFO: rd_valid/empty update 2 edges after the write.
//    count includes the word in the output register; full still at DEPTH.
//  - Thresholds are compared against count; AFULL_THRESH <= DEPTH and
//    AEMPTY_THRESH < DEPTH are required (elaboration-time check).
// STRUCTURE
//  - Shared package fifo_pkg: FWFT mode constants (FIFO_STD=0, FIFO_FWFT=1),
//    default width/depth constants, count-width helper function.
//  - One sub-module: fifo_ram_2p (write port + registered read port with
//    read enable, no reset). Controller holds pointers, count, flags, FWFT stage.
// TESTING
//  1 Reset: assert rst mid-stream with count=5 -> all outputs to reset values
//    immediately; count=0, empty=1 after release.
//  2 Fill: DW=8, AW=4, write 0x00..0x0F -> full=1 after 16th write,
//    almost_full=1 from count 12; 17th write -> overflow pulse, count stays 16.
//  3 Drain FWFT=0: 16 reads -> rd_data 0x00..0x0F in order, each 1 cycle after
//    rd_en with rd_valid pulse; 17th read -> underflow pulse, empty=1.
//  4 Simultaneous wr/rd at count=7 for 20 cycles -> count stays 7, pointers
//    wrap past 15, data order preserved.
//  5 Boundary: full + wr_en + rd_en -> only read accepted, overflow=1, count=15;
//    empty + wr_en + rd_en -> only write accepted, underflow=1, count=1.
//  6 FWFT=1: write 0xA5 into empty -> rd_valid=1, rd_data=0xA5 two edges later
//    without rd_en; rd_en pops -> empty=1, count=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: output-mode selectors, default geometry and count sizing.
package fifo_pkg;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 4;

  // Pointers and count carry one extra bit so 0..DEPTH is representable.
  function automatic int unsigned cnt_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Simple dual-port RAM: synchronous write port, registered read port with enable.
module fifo_ram_2p #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy, registered status flags,
// error pulses and an optional first-word-fall-through output stage.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int unsigned AFULL_THRESH  = 12,
  parameter int unsigned AEMPTY_THRESH = 2,
  parameter int unsigned FWFT          = FIFO_STD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    full,
  output logic                    almost_full,
  output logic                    overflow,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    empty,
  output logic                    almost_empty,
  output logic                    underflow,
  output logic [ADDR_WIDTH:0]     count
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = cnt_width(ADDR_WIDTH);

  if (AFULL_THRESH > DEPTH || AEMPTY_THRESH >= DEPTH) begin : g_bad_thresh
    $error("sync_fifo_ctrl: AFULL_THRESH must be <= DEPTH and AEMPTY_THRESH < DEPTH");
  end

  logic [CW-1:0]         wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]         count_nxt, ram_avail;
  logic                  wr_acc, rd_acc, ram_re;
  logic                  stage_pend, stage_pend_nxt;
  logic                  rd_valid_nxt, empty_nxt, full_nxt;
  logic                  almost_full_nxt, almost_empty_nxt;
  logic                  overflow_nxt, underflow_nxt;
  logic [DATA_WIDTH-1:0] ram_q, rd_data_nxt;

  fifo_ram_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (wr_data),
    .re    (ram_re),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (ram_q)
  );

  // Next-state: acceptance, pointer/count update, RAM read issue, flags.
  always_comb begin
    wr_acc           = 1'b0;
    rd_acc           = 1'b0;
    ram_re           = 1'b0;
    ram_avail        = '0;
    wr_ptr_nxt       = wr_ptr;
    rd_ptr_nxt       = rd_ptr;
    count_nxt        = count;
    stage_pend_nxt   = 1'b0;
    rd_data_nxt      = rd_data;
    rd_valid_nxt     = 1'b0;
    empty_nxt        = empty;
    full_nxt         = full;
    almost_full_nxt  = almost_full;
    almost_empty_nxt = almost_empty;
    overflow_nxt     = 1'b0;
    underflow_nxt    = 1'b0;

    wr_acc    = wr_en && !full;
    rd_acc    = rd_en && !empty;
    ram_avail = wr_ptr - rd_ptr;

    // FWFT prefetches whenever the single output slot is (or is becoming) free.
    if (FWFT == FIFO_FWFT) begin
      ram_re = (ram_avail != '0) && !stage_pend && (!rd_valid || rd_acc);
    end else begin
      ram_re = rd_acc;
    end

    wr_ptr_nxt = wr_ptr + CW'(wr_acc);
    rd_ptr_nxt = rd_ptr + CW'(ram_re);

    unique case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase

    stage_pend_nxt = ram_re;
    if (stage_pend) begin
      rd_data_nxt = ram_q;
    end

    if (FWFT == FIFO_FWFT) begin
      rd_valid_nxt = stage_pend || (rd_valid && !rd_acc);
      empty_nxt    = !rd_valid_nxt;
    end else begin
      rd_valid_nxt = stage_pend;
      empty_nxt    = (count_nxt == '0);
    end

    full_nxt         = (count_nxt == CW'(DEPTH));
    almost_full_nxt  = (count_nxt >= CW'(AFULL_THRESH));
    almost_empty_nxt = (count_nxt <= CW'(AEMPTY_THRESH));
    overflow_nxt     = wr_en && full;
    underflow_nxt    = rd_en && empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      stage_pend   <= 1'b0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      stage_pend   <= stage_pend_nxt;
      rd_data      <= rd_data_nxt;
      rd_valid     <= rd_valid_nxt;
      empty        <= empty_nxt;
      full         <= full_nxt;
      almost_full  <= almost_full_nxt;
      almost_empty <= almost_empty_nxt;
      overflow     <= overflow_nxt;
      underflow    <= underflow_nxt;
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed + random bench for sync_fifo_ctrl in standard and FWFT modes.
module tb_sync_fifo_ctrl;

  logic clk = 1'b0;
  logic rst;

  logic       s_wr_en, s_rd_en, s_full, s_afull, s_ovf, s_rd_valid, s_empty, s_aempty, s_udf;
  logic [7:0] s_wr_data, s_rd_data;
  logic [4:0] s_count;

  logic       f_wr_en, f_rd_en, f_full, f_afull, f_ovf, f_rd_valid, f_empty, f_aempty, f_udf;
  logic [7:0] f_wr_data, f_rd_data;
  logic [4:0] f_count;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(12), .AEMPTY_THRESH(2), .FWFT(0)
  ) u_std (
    .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_data(s_wr_data), .full(s_full),
    .almost_full(s_afull), .overflow(s_ovf), .rd_en(s_rd_en), .rd_data(s_rd_data),
    .rd_valid(s_rd_valid), .empty(s_empty), .almost_empty(s_aempty),
    .underflow(s_udf), .count(s_count)
  );

  sync_fifo_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(12), .AEMPTY_THRESH(2), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .full(f_full),
    .almost_full(f_afull), .overflow(f_ovf), .rd_en(f_rd_en), .rd_data(f_rd_data),
    .rd_valid(f_rd_valid), .empty(f_empty), .almost_empty(f_aempty),
    .underflow(f_udf), .count(f_count)
  );

  int tests = 0;
  int fails = 0;

  // Reference model for the standard-mode instance.
  int         mcount;
  logic [7:0] sb[$];
  logic [7:0] rq[$];
  logic [7:0] fq[$];
  logic [7:0] mlast;
  bit         p_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mcount  = 0;
    sb.delete();
    rq.delete();
    p_valid = 1'b0;
    mlast   = 8'h00;
  endtask

  task automatic std_check(input bit eo, input bit eu, input bit ev);
    chk("count",        32'(s_count),    32'(mcount));
    chk("full",         32'(s_full),     32'(mcount == 16));
    chk("almost_full",  32'(s_afull),    32'(mcount >= 12));
    chk("empty",        32'(s_empty),    32'(mcount == 0));
    chk("almost_empty", 32'(s_aempty),   32'(mcount <= 2));
    chk("overflow",     32'(s_ovf),      32'(eo));
    chk("underflow",    32'(s_udf),      32'(eu));
    chk("rd_valid",     32'(s_rd_valid), 32'(ev));
    if (ev && rq.size() > 0) mlast = rq.pop_front();
    chk("rd_data",      32'(s_rd_data),  32'(mlast));
  endtask

  task automatic std_step(input bit w, input logic [7:0] d, input bit r);
    bit wa, ra, eo, eu, ev;
    wa = w && (mcount != 16);
    ra = r && (mcount != 0);
    eo = w && (mcount == 16);
    eu = r && (mcount == 0);
    s_wr_en = w; s_wr_data = d; s_rd_en = r;
    @(posedge clk);
    ev      = p_valid;
    p_valid = ra;
    if (ra) rq.push_back(sb.pop_front());
    if (wa) sb.push_back(d);
    mcount = mcount + int'(wa) - int'(ra);
    #1;
    s_wr_en = 1'b0; s_rd_en = 1'b0;
    std_check(eo, eu, ev);
  endtask

  initial begin
    rst = 1'b1;
    s_wr_en = 0; s_rd_en = 0; s_wr_data = 0;
    f_wr_en = 0; f_rd_en = 0; f_wr_data = 0;
    model_reset();
    repeat (2) @(negedge clk);
    std_check(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    std_step(0, 8'h00, 0);

    // Reset mid-stream with five words held and a read result on the output.
    for (int i = 0; i < 5; i++) std_step(1, 8'(8'h11 + i), 0);
    std_step(1, 8'h16, 1);
    std_step(0, 8'h00, 0);
    chk("pre_reset_count", 32'(s_count), 32'd5);
    rst = 1'b1;
    #1;
    model_reset();
    std_check(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    std_step(0, 8'h00, 0);
    std_step(0, 8'h00, 1);

    // Fill to full then one dropped write.
    for (int i = 0; i < 16; i++) std_step(1, 8'(i), 0);
    std_step(1, 8'hEE, 0);

    // Drain in order, then one dropped read.
    for (int i = 0; i < 16; i++) std_step(0, 8'h00, 1);
    std_step(0, 8'h00, 1);
    std_step(0, 8'h00, 0);

    // Steady-state simultaneous traffic at count 7 across pointer wrap.
    for (int i = 0; i < 7; i++) std_step(1, 8'(8'h40 + i), 0);
    for (int i = 0; i < 20; i++) std_step(1, 8'(8'h50 + i), 1);
    for (int i = 0; i < 8; i++) std_step(0, 8'h00, 1);
    std_step(0, 8'h00, 0);

    // Full with write+read, then empty with write+read.
    for (int i = 0; i < 16; i++) std_step(1, 8'(8'h80 + i), 0);
    std_step(1, 8'hFF, 1);
    chk("full_wr_rd_count", 32'(s_count), 32'd15);
    for (int i = 0; i < 15; i++) std_step(0, 8'h00, 1);
    std_step(0, 8'h00, 0);
    std_step(1, 8'h77, 1);
    chk("empty_wr_rd_count", 32'(s_count), 32'd1);
    std_step(0, 8'h00, 1);
    std_step(0, 8'h00, 0);

    // Random traffic.
    for (int i = 0; i < 80; i++)
      std_step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 17; i++) std_step(0, 8'h00, 1);
    std_step(0, 8'h00, 0);

    // FWFT: single word falls through two edges after the write.
    f_wr_en = 1'b1; f_wr_data = 8'hA5;
    @(posedge clk); #1;
    f_wr_en = 1'b0;
    chk("fwft_count_after_wr", 32'(f_count),    32'd1);
    chk("fwft_valid_edge1",    32'(f_rd_valid), 32'd0);
    chk("fwft_empty_edge1",    32'(f_empty),    32'd1);
    @(posedge clk); #1;
    chk("fwft_valid_edge2",    32'(f_rd_valid), 32'd0);
    @(posedge clk); #1;
    chk("fwft_valid_edge3",    32'(f_rd_valid), 32'd1);
    chk("fwft_data_edge3",     32'(f_rd_data),  32'hA5);
    chk("fwft_empty_edge3",    32'(f_empty),    32'd0);
    @(posedge clk); #1;
    chk("fwft_valid_hold",     32'(f_rd_valid), 32'd1);
    f_rd_en = 1'b1;
    @(posedge clk); #1;
    chk("fwft_pop_empty",      32'(f_empty),    32'd1);
    chk("fwft_pop_count",      32'(f_count),    32'd0);
    chk("fwft_pop_valid",      32'(f_rd_valid), 32'd0);
    @(posedge clk); #1;
    f_rd_en = 1'b0;
    chk("fwft_underflow",      32'(f_udf),      32'd1);

    // FWFT streaming order.
    for (int i = 0; i < 6; i++) begin
      f_wr_en = 1'b1; f_wr_data = 8'(8'hC0 + i);
      fq.push_back(f_wr_data);
      @(posedge clk); #1;
    end
    f_wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("fwft_stream_count", 32'(f_count), 32'd6);
    f_rd_en = 1'b1;
    for (int i = 0; i < 40 && fq.size() > 0; i++) begin
      if (f_rd_valid) chk("fwft_stream_data", 32'(f_rd_data), 32'(fq.pop_front()));
      @(posedge clk); #1;
    end
    f_rd_en = 1'b0;
    chk("fwft_drain_left", 32'(fq.size()), 32'd0);
    chk("fwft_drain_empty", 32'(f_empty), 32'd1);
    chk("fwft_drain_count", 32'(f_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
